// File: rtl/debounce_pkg.sv
// Shared types and elaboration-time helpers for the push-button debouncer.
// The FSM state type and the counter sizing function live here so that the
// top level and any future siblings agree on encoding and width.
package debounce_pkg;

    // Debouncer / auto-repeat controller states.
    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HELD         = 3'd2,
        REPEAT       = 3'd3,
        RELEASE_WAIT = 3'd4
    } dbnc_state_e;

    // Largest of three positive integers.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (c > m) ? c : m;
        return m;
    endfunction

    // Width of the shared cycle counter: it must hold every terminal value
    // (period - 1) of the three timers, and is never narrower than one bit.
    function automatic int cnt_width(input int debounce_cycles,
                                     input int repeat_delay,
                                     input int repeat_rate);
        int w;
        w = $clog2(max3(debounce_cycles, repeat_delay, repeat_rate));
        w = (w < 1) ? 1 : w;
        return w;
    endfunction

endpackage

// File: rtl/debounce_pulse_gen_sync.sv
// Multi-flop synchronizer for a single asynchronous level. All stages clear
// on the asynchronous active-low reset so a held input is re-sampled afresh
// after every reset.
module bit_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw level through the synchronizer chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/debounce_pulse_gen.sv
// Push-button debouncer with press/release strobes and optional auto-repeat.
// The raw switch is synchronized, then a five-state FSM with one shared
// cycle counter qualifies presses and releases and times the auto-repeat.
// The FSM records each accepted event in a flop; a final output stage
// re-times those events together with the state-derived levels, so pulse,
// release_pulse, level and repeating all change on the same clock edge and
// every port is driven straight from a flop.
module debounce_pulse_gen
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int REPEAT_DELAY    = 50000,
    parameter int REPEAT_RATE     = 10000,
    parameter int REPEAT_EN       = 1,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic pulse,
    output logic release_pulse,
    output logic level,
    output logic repeating
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE);

    // Terminal counts of the three timers sharing the counter.
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RDLY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic             REP_ON    = (REPEAT_EN != 0);

    logic             btn_s;
    dbnc_state_e      state_r;
    dbnc_state_e      state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             pulse_evt_s;
    logic             pulse_evt_r;
    logic             rel_evt_s;
    logic             rel_evt_r;
    logic             level_s;
    logic             repeating_s;

    bit_synchronizer #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (btn_in),
        .q     (btn_s)
    );

    // Next-state, counter and event decode. In every wait state a change of
    // btn_s is tested before the counter terminal so a bounce always wins.
    always_comb begin
        state_s     = state_r;
        cnt_s       = cnt_r;
        pulse_evt_s = 1'b0;
        rel_evt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (btn_s) begin
                    state_s = PRESS_WAIT;
                    cnt_s   = CNT_ZERO;
                end else begin
                    state_s = IDLE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    // Bounce during press qualification: give up silently.
                    state_s = IDLE;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s     = HELD;
                    cnt_s       = CNT_ZERO;
                    pulse_evt_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = CNT_ZERO;
                end else if (REP_ON && (cnt_r == RDLY_LAST)) begin
                    state_s     = REPEAT;
                    cnt_s       = CNT_ZERO;
                    pulse_evt_s = 1'b1;
                end else if (cnt_r == RDLY_LAST) begin
                    // Auto-repeat disabled: park the counter at its terminal.
                    cnt_s = cnt_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            REPEAT: begin
                if (!btn_s) begin
                    state_s = RELEASE_WAIT;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == RATE_LAST) begin
                    cnt_s       = CNT_ZERO;
                    pulse_evt_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    // Release bounce: still pressed, repeat delay restarts.
                    state_s = HELD;
                    cnt_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_s   = IDLE;
                    cnt_s     = CNT_ZERO;
                    rel_evt_s = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = CNT_ZERO;
            end
        endcase
    end

    // FSM state, shared counter and event capture registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= CNT_ZERO;
            pulse_evt_r <= 1'b0;
            rel_evt_r   <= 1'b0;
        end else begin
            state_r     <= state_s;
            cnt_r       <= cnt_s;
            pulse_evt_r <= pulse_evt_s;
            rel_evt_r   <= rel_evt_s;
        end
    end

    // Decode the debounced level and repeat flag from the current state.
    always_comb begin
        level_s     = 1'b0;
        repeating_s = 1'b0;
        case (state_r)
            HELD: begin
                level_s = 1'b1;
            end
            REPEAT: begin
                level_s     = 1'b1;
                repeating_s = 1'b1;
            end
            RELEASE_WAIT: begin
                level_s = 1'b1;
            end
            default: begin
                level_s     = 1'b0;
                repeating_s = 1'b0;
            end
        endcase
    end

    // Output stage: every port is a flop, updated together each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pulse         <= 1'b0;
            release_pulse <= 1'b0;
            level         <= 1'b0;
            repeating     <= 1'b0;
        end else begin
            pulse         <= pulse_evt_r;
            release_pulse <= rel_evt_r;
            level         <= level_s;
            repeating     <= repeating_s;
        end
    end

endmodule

// File: doc/debounce_pulse_gen.md
DEBOUNCE_PULSE_GEN -- requirements
Module: debounce_pulse_gen

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000, number of consecutive stable synchronized samples required to accept a press or release (>=1).
REQ-002 Parameter REPEAT_DELAY, default 50000, number of held cycles after the accepted press before the first auto-repeat pulse (>=1).
REQ-003 Parameter REPEAT_RATE, default 10000, number of cycles between successive auto-repeat pulses (>=1).
REQ-004 Parameter REPEAT_EN, default 1, nonzero enables auto-repeat.
REQ-005 Parameter SYNC_STAGES, default 2, synchronizer depth (>=2).
REQ-006 clk  input  1  single clock; all state updates on its rising edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 btn_in  input  1  raw, asynchronous, bouncing switch level; 1 = pressed.
REQ-009 pulse  output  1  registered single-cycle strobe per accepted press and per auto-repeat; intended to drive a downstream counter enable.
REQ-010 release_pulse  output  1  registered single-cycle strobe per accepted release.
REQ-011 level  output  1  registered debounced button state.
REQ-012 repeating  output  1  registered; high while in REPEAT.

Function
REQ-013 btn_in SHALL pass through SYNC_STAGES flops; only the last stage (btn_s) feeds logic.
REQ-014 States: IDLE, PRESS_WAIT, HELD, REPEAT, RELEASE_WAIT; one shared cycle counter cnt, width = clog2 of max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_RATE), minimum 1.
REQ-015 IDLE: btn_s=1 -> PRESS_WAIT, cnt<=0; else hold.
REQ-016 PRESS_WAIT: btn_s=0 -> IDLE (bounce rejected, no pulse); btn_s=1 and cnt==DEBOUNCE_CYCLES-1 -> HELD, pulse<=1, level<=1, cnt<=0; else cnt++.
REQ-017 HELD: btn_s=0 -> RELEASE_WAIT, cnt<=0; REPEAT_EN and cnt==REPEAT_DELAY-1 -> REPEAT, pulse<=1, cnt<=0; else cnt++ (cnt saturates at REPEAT_DELAY-1 when REPEAT_EN=0).
REQ-018 REPEAT: btn_s=0 -> RELEASE_WAIT, cnt<=0; cnt==REPEAT_RATE-1 -> pulse<=1, cnt<=0; else cnt++.
REQ-019 RELEASE_WAIT: btn_s=1 -> HELD, cnt<=0, no pulse (release bounce rejected, level stays 1, auto-repeat restarts from REPEAT_DELAY); btn_s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE, level<=0, release_pulse<=1; else cnt++.
REQ-020 pulse and release_pulse SHALL be high for exactly one cycle per event and never simultaneously.
REQ-021 Press latency: btn_in stable high from before edge 0 SHALL give pulse=1 exactly after edge SYNC_STAGES+DEBOUNCE_CYCLES+1; release latency identical for release_pulse.
REQ-022 Any btn_s change during a wait state SHALL take priority over counter terminal match in the same cycle.
REQ-023 repeating SHALL equal (state==REPEAT) registered; level SHALL be 1 in HELD, REPEAT, RELEASE_WAIT only.

Reset
REQ-024 rst_n=0 SHALL immediately force state=IDLE, cnt=0, all synchronizer flops=0, pulse=0, release_pulse=0, level=0, repeating=0, independent of clk.
REQ-025 Reset assertion mid-press or mid-repeat SHALL discard progress; after deassertion a still-pressed button SHALL be debounced afresh and produce a new press pulse.

Structure
REQ-026 State enum type and counter-width helper function SHALL live in shared package debounce_pkg.
REQ-027 Synchronizer SHALL be a separate sub-module bit_synchronizer (parameter STAGES, async active-low reset).
REQ-028 All outputs SHALL be driven directly from flops; no combinational path from btn_in to any output.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_RATE=3, REPEAT_EN=1)
REQ-029 Clean press held 9 cycles -> single pulse after edge 7, level=1 from edge 7, no repeat.
REQ-030 Bounce 1,0,1,0 (1 cycle each) then stable 1 -> no pulse during bounce; one pulse 7 edges after final stable rise.
REQ-031 Hold 30 cycles -> press pulse, first repeat pulse 8 cycles later, then every 3 cycles; repeating=1 from first repeat.
REQ-032 Release with a 2-cycle low glitch then high -> no release_pulse, level stays 1, repeat delay restarts.
REQ-033 Clean release -> release_pulse once, 7 edges after btn_in falls, level=0, repeating=0.
REQ-034 rst_n pulled low mid-REPEAT while btn_in stays 1 -> outputs 0 immediately; after release of reset, new press pulse after 7 edges.
